audio_i2s_tx: RTL and testbench

// I2S serializer directly downstream of the audio clock-domain-crossing FIFO.

---
 rtl/audio_i2s_tx.sv | 80 ++++++++
 tb/tb_audio_i2s_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// I2S serializer on audio_mclk: divides mclk into sclk, frames left/right slots
// with a one-bit MSB delay and latches a coherent L/R pair once per frame.
module audio_i2s_tx #(
  parameter int MCLK_DIV   = 4,
  parameter int SLOT_BITS  = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  audio_mclk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] audio_l,
  input  logic [DATA_WIDTH-1:0] audio_r,
  output logic                  audio_sclk,
  output logic                  audio_lrck,
  output logic                  audio_dac,
  output logic                  sample_strobe
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_LEN = BIT_W'(DATA_WIDTH);

  logic [DIV_W-1:0]      div_cnt, div_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt, pos_nxt;
  logic                  fall_tick, frame_wrap, right_nxt, dac_nxt;
  logic [DATA_WIDTH-1:0] shadow_l, shadow_r, shadow_sel;
  logic [IDX_W-1:0]      sel_idx;

  always_comb begin
    fall_tick  = (div_cnt == DIV_LAST);
    div_nxt    = fall_tick ? '0 : div_cnt + 1'b1;
    frame_wrap = fall_tick && (bit_cnt == BIT_LAST);
    bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    right_nxt  = (bit_nxt >= SLOT_LEN);
    pos_nxt    = right_nxt ? bit_nxt - SLOT_LEN : bit_nxt;
    shadow_sel = right_nxt ? shadow_r : shadow_l;
    // Position 1 carries the MSB; position 0 is the I2S one-bit delay.
    sel_idx    = IDX_W'(DATA_LEN - pos_nxt);
    dac_nxt    = 1'b0;
    if ((pos_nxt != '0) && (pos_nxt <= DATA_LEN)) begin
      dac_nxt = shadow_sel[sel_idx];
    end
  end

  // NOTE: the shadow words are ordinary registers, so they get a defined reset
  // value like the rest of the state; nothing is left to power-up contents.
  always_ff @(posedge audio_mclk or posedge reset) begin
    if (reset) begin
      div_cnt       <= '0;
      bit_cnt       <= BIT_LAST;
      audio_sclk    <= 1'b0;
      audio_lrck    <= 1'b1;
      audio_dac     <= 1'b0;
      sample_strobe <= 1'b0;
      shadow_l      <= '0;
      shadow_r      <= '0;
    end else begin
      div_cnt       <= div_nxt;
      audio_sclk    <= (div_nxt >= DIV_HALF);
      sample_strobe <= frame_wrap;
      if (fall_tick) begin
        bit_cnt    <= bit_nxt;
        audio_lrck <= right_nxt;
        audio_dac  <= dac_nxt;
      end
      // Both channels latch on the same edge so a frame never mixes sample pairs.
      if (frame_wrap) begin
        shadow_l <= audio_l;
        shadow_r <= audio_r;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: stimulus queues the expected {lrck,dac}
// per sclk rise, a monitor pops and compares on every rise.
module tb_audio_i2s_tx;

  logic        audio_mclk = 1'b0;
  logic        reset      = 1'b1;
  logic [15:0] audio_l, audio_r;
  logic        audio_sclk, audio_lrck, audio_dac, sample_strobe;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  logic       sclk_q = 1'b0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          delay;
    bit          junk;
  } vec_t;

  vec_t vecs[5];

  audio_i2s_tx #(
    .MCLK_DIV  (4),
    .SLOT_BITS (32),
    .DATA_WIDTH(16)
  ) dut (
    .audio_mclk   (audio_mclk),
    .reset        (reset),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
    .audio_sclk   (audio_sclk),
    .audio_lrck   (audio_lrck),
    .audio_dac    (audio_dac),
    .sample_strobe(sample_strobe)
  );

  always #5 audio_mclk = ~audio_mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sclk rise seen while the DUT still sits at the last bit of the reset frame.
  task automatic push_pre();
    exp_q.push_back(2'b10);
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    logic [15:0] sh;
    logic        b;
    for (int ch = 0; ch < 2; ch++) begin
      for (int p = 0; p < 32; p++) begin
        b = 1'b0;
        if (p >= 1 && p <= 16) begin
          sh = (ch == 0) ? l : r;
          sh = sh << (p - 1);
          b  = sh[15];
        end
        exp_q.push_back({(ch == 1), b});
      end
    end
  endtask

  task automatic wait_strobe();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge audio_mclk);
      if (sample_strobe) found = 1'b1;
    end
    check("strobe_wait", 32'(found), 32'd1);
  endtask

  always @(negedge audio_mclk) begin
    logic [1:0] e;
    if (audio_sclk && !sclk_q && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("serial", 32'({audio_lrck, audio_dac}), 32'(e));
    end
    sclk_q <= audio_sclk;
  end

  initial begin
    int sclk_hi, lrck_lo, strobes, lrck_falls, bad_rise, last_rise, last_strobe, bad_space;
    logic prev_sclk, prev_lrck;

    vecs[0] = '{16'hA5C3, 16'h8001, 0,   1'b0};
    vecs[1] = '{16'h1234, 16'h5678, 0,   1'b0};
    vecs[2] = '{16'h7FFF, 16'h8000, 40,  1'b0};
    vecs[3] = '{16'hFFFF, 16'h0001, 200, 1'b1};
    vecs[4] = '{16'h0000, 16'hFFFF, 10,  1'b1};

    audio_l = vecs[0].l;
    audio_r = vecs[0].r;
    repeat (3) @(negedge audio_mclk);
    check("rst_sclk",   32'(audio_sclk),    32'd0);
    check("rst_lrck",   32'(audio_lrck),    32'd1);
    check("rst_dac",    32'(audio_dac),     32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);

    push_pre();
    push_frame(vecs[0].l, vecs[0].r);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge audio_mclk);
      check("start_sclk",   32'(audio_sclk),    32'(k == 2 || k == 3));
      check("start_lrck",   32'(audio_lrck),    32'(k < 4));
      check("start_strobe", 32'(sample_strobe), 32'(k == 4));
    end

    for (int i = 1; i < 5; i++) begin
      repeat (vecs[i].delay) @(negedge audio_mclk);
      if (vecs[i].junk) begin
        audio_l = ~vecs[i].l;
        audio_r = ~vecs[i].r;
        repeat (5) @(negedge audio_mclk);
      end
      audio_l = vecs[i].l;
      audio_r = vecs[i].r;
      push_frame(vecs[i].l, vecs[i].r);
      wait_strobe();
    end

    // Abort the frame at bit 40, between clock edges.
    repeat (160) @(negedge audio_mclk);
    @(posedge audio_mclk);
    #2;
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("mid_rst_sclk",   32'(audio_sclk),    32'd0);
    check("mid_rst_lrck",   32'(audio_lrck),    32'd1);
    check("mid_rst_dac",    32'(audio_dac),     32'd0);
    check("mid_rst_strobe", 32'(sample_strobe), 32'd0);
    audio_l = 16'hC3A5;
    audio_r = 16'h1248;
    repeat (3) @(negedge audio_mclk);
    push_pre();
    push_frame(16'hC3A5, 16'h1248);
    reset = 1'b0;
    wait_strobe();
    for (int n = 0; n < 400 && exp_q.size() > 0; n++) @(negedge audio_mclk);
    check("drain", 32'(exp_q.size()), 32'd0);

    sclk_hi = 0; lrck_lo = 0; strobes = 0; lrck_falls = 0;
    bad_rise = 0; bad_space = 0; last_rise = -1; last_strobe = -1;
    prev_sclk = audio_sclk;
    prev_lrck = audio_lrck;
    for (int n = 0; n < 1024; n++) begin
      @(negedge audio_mclk);
      if (audio_sclk) sclk_hi++;
      if (!audio_lrck) lrck_lo++;
      if (prev_lrck && !audio_lrck) lrck_falls++;
      if (audio_sclk && !prev_sclk) begin
        if (last_rise >= 0 && n - last_rise != 4) bad_rise++;
        last_rise = n;
      end
      if (sample_strobe) begin
        if (last_strobe >= 0 && n - last_strobe != 256) bad_space++;
        last_strobe = n;
        strobes++;
      end
      prev_sclk = audio_sclk;
      prev_lrck = audio_lrck;
    end
    check("run_sclk_high",    32'(sclk_hi),    32'd512);
    check("run_sclk_period",  32'(bad_rise),   32'd0);
    check("run_lrck_low",     32'(lrck_lo),    32'd512);
    check("run_lrck_falls",   32'(lrck_falls), 32'd4);
    check("run_strobes",      32'(strobes),    32'd4);
    check("run_strobe_space", 32'(bad_space),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
